// File: rtl/cipher_stream_ctrl_pkg.sv
// Shared constants, enums and helpers for the cipher stream controller.
package cipher_stream_ctrl_pkg;

  localparam int P_MOD = 227;

  localparam logic [1:0] MODE_ENC = 2'b01;
  localparam logic [1:0] MODE_DEC = 2'b10;

  // Plaintext alphabet accepted in encrypt mode ('a'..'z').
  localparam logic [7:0] LC_A = 8'h61;
  localparam logic [7:0] LC_Z = 8'h7A;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_CHAR = 2'b01,
    ERR_CFG  = 2'b10,
    ERR_LEN  = 2'b11
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  // A start request is usable only with a known mode and a key inside the field.
  function automatic logic cfg_ok(input logic [1:0] mode, input logic [7:0] key);
    return ((mode == MODE_ENC) || (mode == MODE_DEC)) && ({1'b0, key} < 9'(P_MOD));
  endfunction

endpackage

// File: rtl/cipher_stream_ctrl_if.sv
// Host-side bundle for the cipher stream controller.
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
// valid never depends on ready, and once out_valid is raised the payload
// (out_data/out_last) is held until that transfer completes.
interface cipher_stream_ctrl_if #(
  parameter int MAX_LEN = 32,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
);
  import cipher_stream_ctrl_pkg::*;

  logic             start;
  logic             abort;
  logic [1:0]       mode;
  logic [7:0]       key;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_last;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] char_count;
  state_e           state_dbg;

  modport master (
    output start, abort, mode, key, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, done, err, err_code,
           char_count, state_dbg
  );

  modport slave (
    input  start, abort, mode, key, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, done, err, err_code,
           char_count, state_dbg
  );

endinterface

// File: rtl/cipher_stream_ctrl_char_unit.sv
// Combinational per-character cipher: modular add (encrypt) or subtract
// (decrypt) by the key, plus the legality check for the incoming char.
module cipher_char_unit
  import cipher_stream_ctrl_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [7:0] key,
  input  logic [7:0] char_in,
  output logic [7:0] result,
  output logic       char_ok
);

  logic [8:0] c9;
  logic [8:0] k9;
  logic [8:0] sum9;
  logic [8:0] res9;

  // 9-bit intermediates keep the carry of char+key before the modular fold.
  always_comb begin
    c9      = {1'b0, char_in};
    k9      = {1'b0, key};
    sum9    = c9 + k9;
    res9    = '0;
    char_ok = 1'b0;
    if (mode == MODE_ENC) begin
      char_ok = (char_in >= LC_A) && (char_in <= LC_Z);
      res9    = (sum9 >= 9'(P_MOD)) ? (sum9 - 9'(P_MOD)) : sum9;
    end else if (mode == MODE_DEC) begin
      char_ok = (c9 < 9'(P_MOD));
      res9    = (c9 >= k9) ? (c9 - k9) : (c9 + 9'(P_MOD) - k9);
    end
    result = 8'(res9);
  end

endmodule

// File: rtl/cipher_stream_ctrl.sv
// Message sequencer: latches mode/key on start, streams chars through the
// cipher unit into a one-entry output register, frames on in_last, and
// reports char/config/length faults through a sticky error code.
module cipher_stream_ctrl
  import cipher_stream_ctrl_pkg::*;
#(
  parameter int MAX_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cipher_stream_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  state_e           state_q, state_d;
  logic [1:0]       mode_q;
  logic [7:0]       key_q;
  logic [CNT_W-1:0] count_q;
  logic             out_valid_q;
  logic [7:0]       out_data_q;
  logic             out_last_q;
  logic             err_q;
  err_code_e        err_code_q;

  logic       cfg_good;
  logic       start_hon;
  logic       in_ready;
  logic       accept;
  logic       out_fire;
  logic [7:0] cipher_res;
  logic       char_ok;
  logic       char_err;
  logic       len_err;
  logic       load_out;

  cipher_char_unit u_char (
    .mode    (mode_q),
    .key     (key_q),
    .char_in (bus.in_data),
    .result  (cipher_res),
    .char_ok (char_ok)
  );

  // Handshake qualifiers; a new char may enter while the held one leaves.
  always_comb begin
    cfg_good  = cfg_ok(bus.mode, bus.key);
    start_hon = bus.start && !bus.abort &&
                ((state_q == ST_IDLE) || (state_q == ST_ERROR));
    in_ready  = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
    accept    = bus.in_valid && in_ready;
    out_fire  = out_valid_q && bus.out_ready;
  end

  // Next-state and datapath strobes; abort overrides everything else.
  always_comb begin
    state_d  = state_q;
    char_err = 1'b0;
    len_err  = 1'b0;
    load_out = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (bus.start) state_d = cfg_good ? ST_RUN : ST_ERROR;
      end
      ST_RUN: begin
        if (accept) begin
          if (!char_ok) begin
            char_err = 1'b1;
            state_d  = ST_ERROR;
          end else if ((count_q == CNT_W'(MAX_LEN)) && !bus.in_last) begin
            len_err = 1'b1;
            state_d = ST_ERROR;
          end else begin
            load_out = 1'b1;
            if (bus.in_last) state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (out_fire) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.abort) begin
      state_d  = ST_IDLE;
      char_err = 1'b0;
      len_err  = 1'b0;
      load_out = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Config latch, char counter, output register and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= '0;
      key_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else if (bus.abort) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      count_q     <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      if (start_hon) begin
        mode_q  <= bus.mode;
        key_q   <= bus.key;
        count_q <= '0;
        if (cfg_good) begin
          err_q      <= 1'b0;
          err_code_q <= ERR_NONE;
        end else begin
          err_q      <= 1'b1;
          err_code_q <= ERR_CFG;
        end
      end
      if (char_err) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_CHAR;
      end
      if (len_err) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_LEN;
      end
      // Entering or sitting in ERROR discards any pending output.
      if (state_d == ST_ERROR) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else if (load_out) begin
        out_valid_q <= 1'b1;
        out_data_q  <= cipher_res;
        out_last_q  <= bus.in_last;
        count_q     <= count_q + CNT_W'(1);
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;
  assign bus.char_count = count_q;
  assign bus.state_dbg  = state_q;

endmodule
